wb_stage: RTL and testbench
===========================

# wb_stage

Parametrised writeback stage for the in-order pipeline. It holds one retiring instruction in its own stage register and aligns and extends load data for XLEN = 32 or 64. It waits on a decoupled data-response channel, discards flushed loads safely, exposes a forwarding port and counts retired instructions. It sits between MEM and the register file, with the debug trace port.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- NREG_W, 5, register-index width.
- PC_W, 32, PC width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  MEM offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  PC_W  instruction PC.
- in_result  in  XLEN  ALU result, or load address.
- in_load_op  in  8  one-hot load type: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 LWU, 6 LD, 7 reserved.
- in_res_from_mem  in  1  instruction is a load.
- in_gr_we  in  1  writes a register.
- in_dest  in  NREG_W  destination register.
- data_rvalid  in  1  load response valid.
- data_rdata  in  XLEN  load response data.
- flush  in  1  kill the held instruction.
- rf_we, rf_waddr, rf_wdata  out  1/NREG_W/XLEN  register-file write port.
- fwd_valid  out  1  held instruction will write a nonzero dest.
- fwd_ok  out  1  fwd_data is final this cycle.
- fwd_dest  out  NREG_W  forwarding destination.
- fwd_data  out  XLEN  forwarding value.
- instret  out  64  retired-instruction count.
- debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata  out  PC_W/4/NREG_W/XLEN  trace port.

## Operation
- State machine states:
  - EMPTY: no instruction held.
  - ACTIVE: a non-load is held.
  - WAIT: a load is held and awaits data.
  - DRAIN: a flushed load's response is pending and must be discarded.
- Accept (in_valid & in_ready): latch all in_* fields. Go to WAIT if in_res_from_mem, else to ACTIVE.
- retire = (ACTIVE | (WAIT & data_rvalid)) & ~flush.
- Retire effects in the same cycle:
  - rf_we = retire & gr_we & (dest != 0); writes to r0 are suppressed.
  - debug_wb_rf_we = {4{rf_we}}.
  - instret increments by 1, including instructions with gr_we = 0. instret wraps at 2^64.
- After a retire, go to ACTIVE/WAIT if a new instruction is accepted the same cycle; otherwise go to EMPTY.
- Flush handling:
  - Held ACTIVE: discarded, go to EMPTY, no write.
  - Held WAIT with data_rvalid in the same cycle: response consumed, go to EMPTY.
  - Held WAIT without data_rvalid: go to DRAIN.
  - DRAIN: leave to EMPTY on data_rvalid.
  - flush in EMPTY or DRAIN has no further effect.
- Load alignment uses offset = result[log2(XLEN/8)-1:0]:
  - Byte loads take lane offset.
  - Halfword loads take the lane at offset & ~1.
  - Word loads take the lane at offset & ~3.
  - LD takes the full XLEN word.
  - Signed ops sign-extend to XLEN; U ops zero-extend.
- Misaligned loads (LH/LHU odd offset; LW/LWU offset not multiple of 4) yield 0. Upstream raises ALE.
- Out-of-mode ops (LWU/LD at XLEN = 32, bit 7, or all-zero load_op on a load) yield 0.
- A non-load's write data is result.
- Forwarding outputs:
  - fwd_valid = (ACTIVE | WAIT) & gr_we & (dest != 0).
  - fwd_ok = ACTIVE | (WAIT & data_rvalid).
  - fwd_data equals rf_wdata.

## Timing
- in_ready = ~rst & ~flush & (EMPTY | retire). It is low in DRAIN and in WAIT without data.
- Latency: accepted at cycle t, a non-load retires at t+1. A load retires in the first cycle ≥ t+1 with data_rvalid.
- Throughput is 1 instruction/cycle for back-to-back non-loads.
- Write data comes combinationally from data_rdata in the retire cycle. Data is not buffered.
- data_rvalid asserted in EMPTY or ACTIVE is a protocol violation and is ignored.
- Reset, next edge: state EMPTY and instret 0. All outputs read 0: rf_*, fwd_*, debug_* and in_ready.
- Reset mid-WAIT drops the load, with no DRAIN. The memory side is reset by the same rst.

## Structure
- Package wb_pkg holds:
  - LOAD_OP_W = 8 and the load-op bit indices.
  - The state enum {EMPTY, ACTIVE, WAIT, DRAIN}.
- Sub-module load_align (combinational, parameter XLEN) takes rdata, offset and load_op, and returns the extended value.
- The stage register, FSM and counter live in wb_stage.

## Test plan
- XLEN = 32, back-to-back non-loads: dest 3, result 0x1234 then dest 0, result 5. Required:
  - rf_we high once at t+1 with waddr 3, wdata 0x1234.
  - No write for r0.
  - instret goes 0 → 2.
- XLEN = 32, LB at offset 3 with rdata 0x80FF_0000 gives wdata 0xFFFF_FF80. LHU at offset 2 gives 0x0000_80FF. LH at offset 1 gives 0.
- XLEN = 64, LD with 0x1122334455667788 gives the same value. LWU at offset 4 gives 0x0000_0000_1122_3344.
- A load waits 3 cycles for data_rvalid:
  - in_ready stays 0 and fwd_valid = 1, fwd_ok = 0 while waiting.
  - In the rvalid cycle, retire occurs and in_ready = 1.
- Flush in WAIT with no rvalid:
  - Go to DRAIN with no write and in_ready = 0.
  - When rvalid arrives 2 cycles later, it is discarded and the state goes to EMPTY.
  - Flush and rvalid in the same cycle go directly to EMPTY.
- Assert rst in WAIT, then release. Required: EMPTY, instret 0, all outputs 0, and a new non-load accepted on the first cycle after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

    localparam int unsigned LOAD_OP_W = 8;

    // Bit positions inside the one-hot load-op vector.
    localparam int unsigned LOAD_LB   = 0;
    localparam int unsigned LOAD_LH   = 1;
    localparam int unsigned LOAD_LW   = 2;
    localparam int unsigned LOAD_LBU  = 3;
    localparam int unsigned LOAD_LHU  = 4;
    localparam int unsigned LOAD_LWU  = 5;
    localparam int unsigned LOAD_LD   = 6;
    localparam int unsigned LOAD_RSVD = 7;

    // One-hot encodings used as case items.
    localparam logic [LOAD_OP_W-1:0] OH_LB  = LOAD_OP_W'(1) << LOAD_LB;
    localparam logic [LOAD_OP_W-1:0] OH_LH  = LOAD_OP_W'(1) << LOAD_LH;
    localparam logic [LOAD_OP_W-1:0] OH_LW  = LOAD_OP_W'(1) << LOAD_LW;
    localparam logic [LOAD_OP_W-1:0] OH_LBU = LOAD_OP_W'(1) << LOAD_LBU;
    localparam logic [LOAD_OP_W-1:0] OH_LHU = LOAD_OP_W'(1) << LOAD_LHU;
    localparam logic [LOAD_OP_W-1:0] OH_LWU = LOAD_OP_W'(1) << LOAD_LWU;
    localparam logic [LOAD_OP_W-1:0] OH_LD  = LOAD_OP_W'(1) << LOAD_LD;

    typedef enum logic [1:0] {
        EMPTY,
        ACTIVE,
        WAIT,
        DRAIN
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load-data alignment and extension.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]      rdata_i,
    input  logic [OFF_W-1:0]     offset_i,
    input  logic [LOAD_OP_W-1:0] load_op_i,
    output logic [XLEN-1:0]      data_o
);

    logic [OFF_W-1:0]   h_off;
    logic [OFF_W-1:0]   w_off;
    logic signed [7:0]  b_lane;
    logic signed [15:0] h_lane;
    logic signed [31:0] w_lane;
    logic               h_mis;
    logic               w_mis;

    // Pick the byte/half/word lanes; halves and words use the aligned lane base.
    always_comb begin
        h_off  = offset_i & ~OFF_W'(1);
        w_off  = offset_i & ~OFF_W'(3);
        h_mis  = offset_i[0];
        w_mis  = |offset_i[1:0];
        b_lane = rdata_i[8*offset_i +: 8];
        h_lane = rdata_i[8*h_off +: 16];
        w_lane = rdata_i[8*w_off +: 32];
    end

    // Extend the selected lane; misaligned, reserved and out-of-mode ops give zero.
    always_comb begin
        data_o = '0;
        case (load_op_i)
            OH_LB:  data_o = XLEN'(b_lane);
            OH_LBU: data_o = XLEN'(unsigned'(b_lane));
            OH_LH:  data_o = h_mis ? '0 : XLEN'(h_lane);
            OH_LHU: data_o = h_mis ? '0 : XLEN'(unsigned'(h_lane));
            OH_LW:  data_o = w_mis ? '0 : XLEN'(w_lane);
            OH_LWU: begin
                if (XLEN == 64) begin
                    data_o = w_mis ? '0 : XLEN'(unsigned'(w_lane));
                end
            end
            OH_LD: begin
                if (XLEN == 64) begin
                    data_o = rdata_i;
                end
            end
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, aligns load data, forwards and counts.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG_W = 5,
    parameter int unsigned PC_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_result,
    input  logic [LOAD_OP_W-1:0] in_load_op,
    input  logic                 in_res_from_mem,
    input  logic                 in_gr_we,
    input  logic [NREG_W-1:0]    in_dest,
    input  logic                 data_rvalid,
    input  logic [XLEN-1:0]      data_rdata,
    input  logic                 flush,
    output logic                 rf_we,
    output logic [NREG_W-1:0]    rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 fwd_valid,
    output logic                 fwd_ok,
    output logic [NREG_W-1:0]    fwd_dest,
    output logic [XLEN-1:0]      fwd_data,
    output logic [63:0]          instret,
    output logic [PC_W-1:0]      debug_wb_pc,
    output logic [3:0]           debug_wb_rf_we,
    output logic [NREG_W-1:0]    debug_wb_rf_wnum,
    output logic [XLEN-1:0]      debug_wb_rf_wdata
);

    localparam int unsigned OFF_W = $clog2(XLEN / 8);

    wb_state_e              state_q, state_d;
    logic [PC_W-1:0]        pc_q;
    logic [XLEN-1:0]        result_q;
    logic [LOAD_OP_W-1:0]   load_op_q;
    logic                   from_mem_q;
    logic                   gr_we_q;
    logic [NREG_W-1:0]      dest_q;
    logic [63:0]            instret_q;

    logic                   retire;
    logic                   accept;
    logic                   dest_nz;
    logic [XLEN-1:0]        load_data;
    logic [XLEN-1:0]        wdata;

    load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .rdata_i   (data_rdata),
        .offset_i  (result_q[OFF_W-1:0]),
        .load_op_i (load_op_q),
        .data_o    (load_data)
    );

    // State register; reset drops any held load without draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over retire, a pending response forces DRAIN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) state_d = in_res_from_mem ? WAIT : ACTIVE;
            end
            ACTIVE: begin
                if (accept) state_d = in_res_from_mem ? WAIT : ACTIVE;
                else        state_d = EMPTY;
            end
            WAIT: begin
                if (flush) begin
                    state_d = data_rvalid ? EMPTY : DRAIN;
                end else if (data_rvalid) begin
                    if (accept) state_d = in_res_from_mem ? WAIT : ACTIVE;
                    else        state_d = EMPTY;
                end
            end
            DRAIN: begin
                if (data_rvalid) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake, retire, register-file, forwarding and trace outputs.
    always_comb begin
        retire   = ((state_q == ACTIVE) || ((state_q == WAIT) && data_rvalid)) && !flush;
        in_ready = !rst && !flush && ((state_q == EMPTY) || retire);
        accept   = in_valid && in_ready;
        dest_nz  = (dest_q != '0);
        wdata    = from_mem_q ? load_data : result_q;

        rf_we    = retire && gr_we_q && dest_nz;
        rf_waddr = dest_q;
        rf_wdata = wdata;

        fwd_valid = ((state_q == ACTIVE) || (state_q == WAIT)) && gr_we_q && dest_nz;
        fwd_ok    = (state_q == ACTIVE) || ((state_q == WAIT) && data_rvalid);
        fwd_dest  = dest_q;
        fwd_data  = wdata;

        instret           = instret_q;
        debug_wb_pc       = pc_q;
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = dest_q;
        debug_wb_rf_wdata = wdata;
    end

    // Stage register; cleared on reset so every output reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            result_q   <= '0;
            load_op_q  <= '0;
            from_mem_q <= 1'b0;
            gr_we_q    <= 1'b0;
            dest_q     <= '0;
        end else if (accept) begin
            pc_q       <= in_pc;
            result_q   <= in_result;
            load_op_q  <= in_load_op;
            from_mem_q <= in_res_from_mem;
            gr_we_q    <= in_gr_we;
            dest_q     <= in_dest;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: one 32-bit and one 64-bit instance on shared stimulus.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [63:0] in_result;
    logic [7:0]  in_load_op;
    logic        in_res_from_mem;
    logic        in_gr_we;
    logic [4:0]  in_dest;
    logic        data_rvalid;
    logic [63:0] data_rdata;
    logic        flush;

    logic        in_ready_a, rf_we_a, fwd_valid_a, fwd_ok_a;
    logic [4:0]  rf_waddr_a, fwd_dest_a, dbg_wnum_a;
    logic [31:0] rf_wdata_a, fwd_data_a, dbg_wdata_a, dbg_pc_a;
    logic [63:0] instret_a;
    logic [3:0]  dbg_we_a;

    logic        in_ready_b, rf_we_b, fwd_valid_b, fwd_ok_b;
    logic [4:0]  rf_waddr_b, fwd_dest_b, dbg_wnum_b;
    logic [63:0] rf_wdata_b, fwd_data_b, dbg_wdata_b;
    logic [31:0] dbg_pc_b;
    logic [63:0] instret_b;
    logic [3:0]  dbg_we_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .NREG_W(5), .PC_W(32)) u_dut32 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready_a),
        .in_pc (in_pc), .in_result (in_result[31:0]), .in_load_op (in_load_op),
        .in_res_from_mem (in_res_from_mem), .in_gr_we (in_gr_we), .in_dest (in_dest),
        .data_rvalid (data_rvalid), .data_rdata (data_rdata[31:0]), .flush (flush),
        .rf_we (rf_we_a), .rf_waddr (rf_waddr_a), .rf_wdata (rf_wdata_a),
        .fwd_valid (fwd_valid_a), .fwd_ok (fwd_ok_a), .fwd_dest (fwd_dest_a),
        .fwd_data (fwd_data_a), .instret (instret_a), .debug_wb_pc (dbg_pc_a),
        .debug_wb_rf_we (dbg_we_a), .debug_wb_rf_wnum (dbg_wnum_a),
        .debug_wb_rf_wdata (dbg_wdata_a)
    );

    wb_stage #(.XLEN(64), .NREG_W(5), .PC_W(32)) u_dut64 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready_b),
        .in_pc (in_pc), .in_result (in_result), .in_load_op (in_load_op),
        .in_res_from_mem (in_res_from_mem), .in_gr_we (in_gr_we), .in_dest (in_dest),
        .data_rvalid (data_rvalid), .data_rdata (data_rdata), .flush (flush),
        .rf_we (rf_we_b), .rf_waddr (rf_waddr_b), .rf_wdata (rf_wdata_b),
        .fwd_valid (fwd_valid_b), .fwd_ok (fwd_ok_b), .fwd_dest (fwd_dest_b),
        .fwd_data (fwd_data_b), .instret (instret_b), .debug_wb_pc (dbg_pc_b),
        .debug_wb_rf_we (dbg_we_b), .debug_wb_rf_wnum (dbg_wnum_b),
        .debug_wb_rf_wdata (dbg_wdata_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a load and let it be accepted; the stage is then in WAIT.
    task automatic issue_load(input logic [7:0] op, input logic [63:0] addr,
                              input logic [4:0] dest);
        in_valid        = 1'b1;
        in_res_from_mem = 1'b1;
        in_gr_we        = 1'b1;
        in_load_op      = op;
        in_result       = addr;
        in_dest         = dest;
        in_pc           = 32'h200;
        step();
        in_valid        = 1'b0;
        in_res_from_mem = 1'b0;
    endtask

    task automatic resp(input logic [63:0] rd);
        data_rvalid = 1'b1;
        data_rdata  = rd;
        #1;
    endtask

    task automatic end_resp();
        step();
        data_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_result = '0; in_load_op = '0;
        in_res_from_mem = 1'b0; in_gr_we = 1'b0; in_dest = '0;
        data_rvalid = 1'b0; data_rdata = '0; flush = 1'b0;
        step();
        step();
        chk("rst_ready", in_ready_a, 0);
        chk("rst_instret", instret_a, 0);
        chk("rst_we", rf_we_a, 0);
        chk("rst_fwd_valid", fwd_valid_b, 0);
        rst = 1'b0;

        // Back-to-back non-loads: r3 then r0.
        in_valid = 1'b1; in_gr_we = 1'b1; in_dest = 5'd3; in_result = 64'h1234;
        in_pc = 32'h100;
        #1 chk("alu_ready", in_ready_a, 1);
        step();
        in_dest = 5'd0; in_result = 64'd5; in_pc = 32'h104;
        #1;
        chk("alu_we", rf_we_a, 1);
        chk("alu_waddr", rf_waddr_a, 3);
        chk("alu_wdata", rf_wdata_a, 32'h1234);
        chk("alu_dbg_we", dbg_we_a, 4'hF);
        chk("alu_dbg_pc", dbg_pc_a, 32'h100);
        chk("alu_fwd", {fwd_valid_a, fwd_ok_a}, 2'b11);
        chk("alu_b2b_ready", in_ready_a, 1);
        step();
        in_valid = 1'b0;
        #1;
        chk("r0_we", rf_we_a, 0);
        chk("r0_dbg_we", dbg_we_a, 0);
        chk("r0_fwd_valid", fwd_valid_a, 0);
        chk("r0_instret", instret_a, 1);
        step();
        chk("alu_instret", instret_a, 2);

        // Load alignment on both widths.
        issue_load(8'h01, 64'd3, 5'd5);
        resp(64'h80FF_0000);
        chk("lb_we", rf_we_a, 1);
        chk("lb32", rf_wdata_a, 32'hFFFF_FF80);
        chk("lb64", rf_wdata_b, 64'hFFFF_FFFF_FFFF_FF80);
        end_resp();
        issue_load(8'h10, 64'd2, 5'd5);
        resp(64'h80FF_0000);
        chk("lhu32", rf_wdata_a, 32'h0000_80FF);
        chk("lhu64", rf_wdata_b, 64'h80FF);
        end_resp();
        issue_load(8'h02, 64'd1, 5'd5);
        resp(64'h80FF_0000);
        chk("lh_mis32", rf_wdata_a, 0);
        chk("lh_mis64", rf_wdata_b, 0);
        end_resp();
        issue_load(8'h04, 64'd0, 5'd5);
        resp(64'h80FF_0000);
        chk("lw32", rf_wdata_a, 32'h80FF_0000);
        chk("lw64", rf_wdata_b, 64'hFFFF_FFFF_80FF_0000);
        end_resp();
        issue_load(8'h40, 64'd0, 5'd5);
        resp(64'h1122_3344_5566_7788);
        chk("ld64", rf_wdata_b, 64'h1122_3344_5566_7788);
        chk("ld32_oom", rf_wdata_a, 0);
        end_resp();
        issue_load(8'h20, 64'd4, 5'd5);
        resp(64'h1122_3344_5566_7788);
        chk("lwu64", rf_wdata_b, 64'h0000_0000_1122_3344);
        chk("lwu32_oom", rf_wdata_a, 0);
        end_resp();
        issue_load(8'h80, 64'd0, 5'd5);
        resp(64'hFFFF_FFFF_FFFF_FFFF);
        chk("rsvd32", rf_wdata_a, 0);
        chk("rsvd64", rf_wdata_b, 0);
        end_resp();
        chk("load_instret", instret_a, 9);

        // Load waiting three cycles for its response.
        issue_load(8'h04, 64'd0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            chk("wait_ready", in_ready_a, 0);
            chk("wait_fwd", {fwd_valid_a, fwd_ok_a}, 2'b10);
            chk("wait_we", rf_we_a, 0);
            step();
        end
        resp(64'hDEAD_BEEF);
        chk("wait_ret_we", rf_we_a, 1);
        chk("wait_ret_ready", in_ready_a, 1);
        chk("wait_fwd_ok", fwd_ok_a, 1);
        chk("wait_fwd_data", fwd_data_a, 32'hDEAD_BEEF);
        chk("wait_data64", rf_wdata_b, 64'hFFFF_FFFF_DEAD_BEEF);
        end_resp();
        chk("wait_instret", instret_a, 10);

        // Flush in WAIT without response, then discard the late response.
        issue_load(8'h04, 64'd0, 5'd7);
        flush = 1'b1;
        #1;
        chk("fl_we", rf_we_a, 0);
        chk("fl_ready", in_ready_a, 0);
        step();
        flush = 1'b0;
        #1;
        chk("drain_ready", in_ready_a, 0);
        chk("drain_fwd_valid", fwd_valid_a, 0);
        step();
        resp(64'h1);
        chk("drain_rv_we", rf_we_a, 0);
        chk("drain_rv_ready", in_ready_a, 0);
        end_resp();
        chk("drain_empty", in_ready_a, 1);
        chk("drain_instret", instret_a, 10);

        // Flush and response in the same cycle.
        issue_load(8'h04, 64'd0, 5'd7);
        flush = 1'b1;
        resp(64'h2);
        chk("flrv_we", rf_we_a, 0);
        step();
        flush = 1'b0;
        data_rvalid = 1'b0;
        #1;
        chk("flrv_empty", in_ready_a, 1);
        chk("flrv_instret", instret_a, 10);

        // Flush of a held non-load.
        in_valid = 1'b1; in_res_from_mem = 1'b0; in_gr_we = 1'b1; in_dest = 5'd4;
        in_result = 64'h77;
        step();
        in_valid = 1'b0; flush = 1'b1;
        #1 chk("flact_we", rf_we_a, 0);
        step();
        flush = 1'b0;
        #1;
        chk("flact_empty", in_ready_a, 1);
        chk("flact_instret", instret_a, 10);

        // Reset while a load waits.
        issue_load(8'h04, 64'd8, 5'd7);
        rst = 1'b1;
        data_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        chk("rw_instret", instret_b, 0);
        chk("rw_ready", in_ready_b, 0);
        chk("rw_we", rf_we_b, 0);
        chk("rw_fwd", {fwd_valid_b, fwd_ok_b}, 0);
        chk("rw_fwd_data", fwd_data_b, 0);
        chk("rw_dbg_pc", dbg_pc_b, 0);
        chk("rw_waddr", rf_waddr_b, 0);
        rst = 1'b0;
        in_valid = 1'b1; in_gr_we = 1'b1; in_dest = 5'd9; in_result = 64'h55;
        #1 chk("rw_accept", in_ready_b, 1);
        step();
        in_valid = 1'b0;
        #1;
        chk("rw_ret_we", rf_we_b, 1);
        chk("rw_ret_data", rf_wdata_b, 64'h55);
        step();
        chk("rw_ret_instret", instret_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
